// File: rtl/tx_frame_serializer.sv
// ============================================================================
// tx_frame_serializer
// ----------------------------------------------------------------------------
// Purpose:
//   This is the TX back end behind the HPS register driver. Bytes that the
//   driver writes are held in a byte FIFO. On start_tx the block sends exactly
//   size_fifo_tx bytes on tx_out as UART-style frames. Each frame is a start
//   bit (0), 8 data bits sent LSB first, and a stop bit (1). ready_tx goes
//   back to 1 once the block is idle again.
//
// Optional feature (compile-time macro TX_PARITY_EN):
//   When TX_PARITY_EN is defined, an even-parity bit (the XOR of the 8 data
//   bits) goes between data bit 7 and the stop bit, which makes an 11-bit
//   frame. When it is undefined the frame has 10 bits and there is no
//   PARITY state.
//
// Parameters:
//   DEPTH       FIFO depth in bytes (power of 2, >= 2)
//   BIT_PERIOD  clk cycles per serial bit (>= 2)
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   synchronous, active-high
//   data_tx       in   byte to enqueue
//   wren_fifo_tx  in   enqueue strobe, one byte per cycle while high
//   size_fifo_tx  in   packet byte count, sampled on start_tx
//   start_tx      in   single-cycle start pulse
//   ready_tx      out  1 = idle, start_tx can be accepted
//   tx_out        out  serial line, idles high
//   fifo_level    out  bytes currently held in the FIFO
//   overflow      out  sticky flag: a write was attempted while full
//   start_err     out  1-cycle pulse: start_tx was rejected
// ============================================================================
module tx_frame_serializer #(
    parameter int DEPTH      = 256,
    parameter int BIT_PERIOD = 50
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_tx,
    input  logic                   wren_fifo_tx,
    input  logic [7:0]             size_fifo_tx,
    input  logic                   start_tx,
    output logic                   ready_tx,
    output logic                   tx_out,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   start_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [BW-1:0] BAUD_LAST  = BW'(BIT_PERIOD - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

    state_t        state_q;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          overflow_q;
    logic [7:0]    remaining_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitCnt_q;
    logic [BW-1:0] baudCnt_q;
    logic          tx_q;
    logic          ready_q;
    logic          startErr_q;
`ifdef TX_PARITY_EN
    logic          parity_q;
`endif

    logic       fifoFull;
    logic       push;
    logic       pop;
    logic       startOk;
    logic [7:0] headByte;

    assign fifoFull = (level_q == FULL_LEVEL);
    assign push     = wren_fifo_tx && !fifoFull;
    assign pop      = (state_q == LOAD);
    assign headByte = mem[rdPtr_q];

    // The FSM only pops while remaining != 0. A start is accepted only if
    // level >= size, and writes can only raise the level after that, so the
    // FIFO can never be read while it is empty.
    assign startOk  = (size_fifo_tx != 8'd0) &&
                      (32'(level_q) >= 32'(size_fifo_tx));

    // Next FIFO fill level. A push and a pop in the same cycle cancel out.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // FIFO storage. It has no reset: a location is only read after it has
    // been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= data_tx;
        end
    end

    // FIFO pointers, fill level and the sticky overflow flag. Both pointers
    // are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            level_q <= level_d;
            if (wren_fifo_tx && fifoFull) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame sequencer. tx_q is loaded with the level of the state being
    // entered, so the line changes on the same edge as the state and has no
    // combinational path to the pin. START, DATA, PARITY and STOP each hold
    // their bit for BIT_PERIOD cycles, counted by baudCnt_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            baudCnt_q   <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            startErr_q  <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            startErr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_tx) begin
                        if (startOk) begin
                            remaining_q <= size_fifo_tx;
                            ready_q     <= 1'b0;
                            state_q     <= LOAD;
                        end else begin
                            startErr_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    shift_q     <= headByte;
`ifdef TX_PARITY_EN
                    parity_q    <= ^headByte;
`endif
                    remaining_q <= remaining_q - 1'b1;
                    baudCnt_q   <= '0;
                    tx_q        <= 1'b0;
                    state_q     <= START;
                end
                START: begin
                    if (baudCnt_q == BAUD_LAST) begin
                        baudCnt_q <= '0;
                        bitCnt_q  <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baudCnt_q == BAUD_LAST) begin
                        baudCnt_q <= '0;
                        if (bitCnt_q == 3'd7) begin
`ifdef TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                            shift_q  <= {1'b0, shift_q[7:1]};
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    if (baudCnt_q == BAUD_LAST) begin
                        baudCnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baudCnt_q == BAUD_LAST) begin
                        baudCnt_q <= '0;
                        if (remaining_q != 8'd0) begin
                            state_q <= LOAD;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_tx   = ready_q;
    assign tx_out     = tx_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign start_err  = startErr_q;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// ============================================================================
// tb_tx_frame_serializer
// ----------------------------------------------------------------------------
// Directed bench for tx_frame_serializer with DEPTH=16 and BIT_PERIOD=4.
// The stimulus side pushes the byte expected for each frame into expQ. A
// separate monitor watches tx_out for start bits, captures each complete
// frame one cycle at a time, and compares it with the waveform built from
// the byte at the head of the queue. Inputs are driven 1 ns after posedge,
// and outputs are sampled on negedge.
// ============================================================================
module tb_tx_frame_serializer;

    localparam int DEPTH = 16;
    localparam int BP    = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FCYC    = NBITS * BP;
    localparam int PKT_CYC = FCYC + 1;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic [7:0] data_tx      = 8'h00;
    logic       wren_fifo_tx = 1'b0;
    logic [7:0] size_fifo_tx = 8'h00;
    logic       start_tx     = 1'b0;
    logic       ready_tx;
    logic       tx_out;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       start_err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expQ[$];
    logic       traceQ[$];

    tx_frame_serializer #(
        .DEPTH      (DEPTH),
        .BIT_PERIOD (BP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_tx      (data_tx),
        .wren_fifo_tx (wren_fifo_tx),
        .size_fifo_tx (size_fifo_tx),
        .start_tx     (start_tx),
        .ready_tx     (ready_tx),
        .tx_out       (tx_out),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .start_err    (start_err)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Compare one value and report it if it differs.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the inputs for exactly one sampled clock cycle.
    task automatic applyStimulus(input logic wr, input logic [7:0] d,
                                 input logic st, input logic [7:0] sz);
        @(posedge clk);
        #1;
        wren_fifo_tx = wr;
        data_tx      = d;
        start_tx     = st;
        size_fifo_tx = sz;
    endtask

    // Build the expected cycle-by-cycle tx_out waveform for one frame.
    // Bit i of the result is the line level i cycles after the start bit
    // begins.
    function automatic logic [63:0] frameWave(input logic [7:0] b);
        logic [63:0] w;
        logic        bitv;
        w = '0;
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0) begin
                bitv = 1'b0;
            end else if (k <= 8) begin
                bitv = b[k-1];
`ifdef TX_PARITY_EN
            end else if (k == 9) begin
                bitv = ^b;
`endif
            end else begin
                bitv = 1'b1;
            end
            for (int j = 0; j < BP; j++) begin
                w[k*BP+j] = bitv;
            end
        end
        return w;
    endfunction

    // Send the start pulse, then count the cycles during which ready_tx is
    // low (within a time limit), recording tx_out for each of those cycles.
    task automatic runPacket(input logic [7:0] sz, input int expLow, input string name);
        int low;
        applyStimulus(1'b0, 8'h00, 1'b1, sz);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        traceQ.delete();
        low = 0;
        @(negedge clk);
        while (ready_tx == 1'b0 && low < expLow + 100) begin
            traceQ.push_back(tx_out);
            low++;
            @(negedge clk);
        end
        checkOutput({name, " ready_tx low cycles"}, low, expLow);
        if (traceQ.size() >= 2) begin
            checkOutput({name, " LOAD high then start bit"}, {traceQ[0], traceQ[1]}, 2'b10);
        end else begin
            checkOutput({name, " LOAD high then start bit"}, 2'b11, 2'b10);
        end
    endtask

    // Wait for ready_tx, up to a fixed number of cycles.
    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_tx == 1'b0 && n < budget) begin
            n++;
            @(negedge clk);
        end
        checkOutput({name, " returned to idle"}, ready_tx, 1'b1);
    endtask

    // Frame monitor. It captures each frame from the falling edge of the
    // start bit. A frame that reset cuts short is dropped without popping a
    // byte from expQ.
    initial begin : monitor
        logic        prevTx;
        logic        aborted;
        logic [63:0] cap;
        logic [7:0]  expByte;
        prevTx = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevTx = 1'b1;
            end else if (prevTx && !tx_out) begin
                cap     = '0;
                aborted = 1'b0;
                for (int i = 1; i < FCYC; i++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    cap[i] = tx_out;
                end
                if (!aborted) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL frame: got unexpected frame 0x%0h with no byte queued", cap);
                    end else begin
                        expByte = expQ.pop_front();
                        checkOutput($sformatf("frame byte 0x%02h", expByte), cap, frameWave(expByte));
                    end
                    prevTx = tx_out;
                end else begin
                    prevTx = 1'b1;
                end
            end else begin
                prevTx = tx_out;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin : stimulus
        int   bad;
        logic tb0;
        logic tb1;
        logic tb2;
        logic tb3;

        // Reset values, then 100 idle cycles.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset values", {ready_tx, tx_out, fifo_level, overflow, start_err},
                    {1'b1, 1'b1, 5'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(ready_tx === 1'b1 && tx_out === 1'b1 && fifo_level === 5'd0 &&
                  overflow === 1'b0 && start_err === 1'b0)) begin
                bad++;
            end
        end
        checkOutput("idle hold violations", bad, 0);

        // Single frame 0xA5.
        applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("level after one write", fifo_level, 5'd1);
        expQ.push_back(8'hA5);
        runPacket(8'd1, PKT_CYC, "single");
        checkOutput("single level after", fifo_level, 5'd0);
        checkOutput("single queue drained", expQ.size(), 0);

        // Back-to-back packet of three bytes.
        applyStimulus(1'b1, 8'h01, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h02, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h03, 1'b0, 8'h00);
        expQ.push_back(8'h01);
        expQ.push_back(8'h02);
        expQ.push_back(8'h03);
        runPacket(8'd3, 3 * PKT_CYC, "b2b");
        if (traceQ.size() >= 3 * PKT_CYC) begin
            tb0 = traceQ[PKT_CYC];
            tb1 = traceQ[PKT_CYC + 1];
            tb2 = traceQ[2 * PKT_CYC];
            tb3 = traceQ[2 * PKT_CYC + 1];
        end else begin
            tb0 = 1'b0;
            tb1 = 1'b1;
            tb2 = 1'b0;
            tb3 = 1'b1;
        end
        checkOutput("b2b one-cycle gaps", {tb0, tb1, tb2, tb3}, 4'b1010);
        checkOutput("b2b level after", fifo_level, 5'd0);
        checkOutput("b2b queue drained", expQ.size(), 0);

        // Reject a start with size 0.
        applyStimulus(1'b0, 8'h00, 1'b1, 8'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("size0 start_err/ready/tx", {start_err, ready_tx, tx_out}, 3'b111);
        @(negedge clk);
        checkOutput("size0 pulse ends", {start_err, ready_tx, tx_out}, 3'b011);

        // Reject a start with size 4 when only 3 bytes are queued.
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h22, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h33, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'd4);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("size4 start_err/ready/tx", {start_err, ready_tx, tx_out}, 3'b111);
        @(negedge clk);
        checkOutput("size4 pulse ends, level kept", {start_err, ready_tx, tx_out, fifo_level},
                    {1'b0, 1'b1, 1'b1, 5'd3});
        expQ.push_back(8'h11);
        expQ.push_back(8'h22);
        expQ.push_back(8'h33);
        runPacket(8'd3, 3 * PKT_CYC, "drain after reject");
        checkOutput("drain queue empty", expQ.size(), 0);

        // Write and pop in the same cycle (write during LOAD).
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'hBB, 1'b0, 8'h00);
        expQ.push_back(8'hAA);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'd1);
        applyStimulus(1'b1, 8'hCC, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("write+pop level unchanged", {ready_tx, fifo_level}, {1'b0, 5'd2});
        waitIdle(PKT_CYC + 50, "write+pop packet");
        expQ.push_back(8'hBB);
        expQ.push_back(8'hCC);
        runPacket(8'd2, 2 * PKT_CYC, "after write+pop");
        checkOutput("after write+pop level", fifo_level, 5'd0);

        // Overflow: 17 writes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(8'h30 + 8'(i * 7)), 1'b0, 8'h00);
            if (i < 16) begin
                expQ.push_back(8'(8'h30 + 8'(i * 7)));
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("overflow level/flag", {fifo_level, overflow}, {5'd16, 1'b1});
        runPacket(8'd16, 16 * PKT_CYC, "overflow drain");
        checkOutput("overflow drained level/sticky", {fifo_level, overflow}, {5'd0, 1'b1});
        checkOutput("overflow queue empty", expQ.size(), 0);

        // Reset in the middle of the DATA phase of frame 2 of 3.
        applyStimulus(1'b1, 8'h44, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h66, 1'b0, 8'h00);
        expQ.push_back(8'h44);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'd3);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (60) @(negedge clk);
        checkOutput("pre-reset busy/level", {ready_tx, fifo_level}, {1'b0, 5'd1});
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid-frame reset outputs", {tx_out, ready_tx, fifo_level, overflow, start_err},
                    {1'b1, 1'b1, 5'd0, 1'b0, 1'b0});
        checkOutput("mid-frame reset queue", expQ.size(), 0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
        expQ.push_back(8'h5A);
        runPacket(8'd1, PKT_CYC, "post reset");
        checkOutput("post reset level", fifo_level, 5'd0);

        repeat (5) @(negedge clk);
        checkOutput("final queue empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
